// File: rtl/hazard_pipe_ctrl_pkg.sv
// Shared types for the hazard/pipeline control slice.
// Holds the register-index width, the stage-record layouts of the
// ID/EX, EX/MEM and MEM/WB pipeline registers, and their bubble values.
package hazard_pipe_ctrl_pkg;

  localparam int unsigned REG_AW = 5;

  // ID/EX stage record
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              regwren;
    logic              memread;
  } idex_t;

  // EX/MEM stage record
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwren;
    logic              memread;
  } exmem_t;

  // MEM/WB stage record
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwren;
  } memwb_t;

  // A bubble is an all-zero record, so it can never match in forwarding.
  localparam idex_t  IDEX_BUBBLE  = '0;
  localparam exmem_t EXMEM_BUBBLE = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/hazard_pipe_ctrl_sat_counter.sv
// Saturating event counter.
// Ports: clk, rst (sync, active-high), inc (count one event this cycle),
//        count (current value; sticks at all-ones).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Increment unless already saturated
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// Pipeline hazard controller.
// Tracks rd/control metadata through ID/EX, EX/MEM and MEM/WB, exports the
// stage-tagged register fields used by the forwarding unit, detects
// load-use hazards (stall + bubble), sequences mispredict flushes and
// freezes the whole pipe while data memory is not ready.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_*                           decoded ID-stage instruction
//   ex_flush                       mispredict resolved in EX this cycle
//   mem_stall                      data memory wait; freeze everything
//   IDEX_Rs1/Rs2, EXMEM_Rd, MEMWB_Rd, *_RegWrEn   forwarding-unit view
//   stall_fe, flush_ifid           front-end control (combinational)
//   loaduse_cnt, flush_cnt         saturating event counters
// REG_AW must match hazard_pipe_ctrl_pkg::REG_AW (stage records use it).
module hazard_pipe_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwren,
  input  logic              id_memread,
  input  logic              ex_flush,
  input  logic              mem_stall,
  output logic [REG_AW-1:0] IDEX_Rs1,
  output logic [REG_AW-1:0] IDEX_Rs2,
  output logic [REG_AW-1:0] EXMEM_Rd,
  output logic [REG_AW-1:0] MEMWB_Rd,
  output logic              EXMEM_RegWrEn,
  output logic              MEMWB_RegWrEn,
  output logic              stall_fe,
  output logic              flush_ifid,
  output logic [CNT_W-1:0]  loaduse_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  import hazard_pipe_ctrl_pkg::idex_t;
  import hazard_pipe_ctrl_pkg::exmem_t;
  import hazard_pipe_ctrl_pkg::memwb_t;
  import hazard_pipe_ctrl_pkg::IDEX_BUBBLE;
  import hazard_pipe_ctrl_pkg::EXMEM_BUBBLE;
  import hazard_pipe_ctrl_pkg::MEMWB_BUBBLE;

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic load_use_c;
  logic flush_inc_c;
  logic loaduse_inc_c;

  // Load in EX whose non-x0 destination is read by the ID instruction
  always_comb begin
    load_use_c = idex_q.valid && idex_q.memread && (idex_q.rd != '0) && id_valid &&
                 ((id_use_rs1 && (id_rs1 == idex_q.rd)) ||
                  (id_use_rs2 && (id_rs2 == idex_q.rd)));
  end

  // Next-state and front-end control; priority rst > mem_stall > flush > load-use
  always_comb begin
    idex_d        = idex_q;
    exmem_d       = exmem_q;
    memwb_d       = memwb_q;
    stall_fe      = 1'b0;
    flush_ifid    = 1'b0;
    flush_inc_c   = 1'b0;
    loaduse_inc_c = 1'b0;

    if (rst) begin
      idex_d  = IDEX_BUBBLE;
      exmem_d = EXMEM_BUBBLE;
      memwb_d = MEMWB_BUBBLE;
    end else if (mem_stall) begin
      // Freeze: held inputs re-present any flush/load-use after release
      stall_fe = 1'b1;
    end else begin
      exmem_d.valid   = idex_q.valid;
      exmem_d.rd      = idex_q.rd;
      exmem_d.regwren = idex_q.regwren;
      exmem_d.memread = idex_q.memread;
      memwb_d.valid   = exmem_q.valid;
      memwb_d.rd      = exmem_q.rd;
      memwb_d.regwren = exmem_q.regwren;

      if (ex_flush) begin
        // Branch advances; the ID instruction is squashed, no stall
        idex_d      = IDEX_BUBBLE;
        flush_ifid  = 1'b1;
        flush_inc_c = 1'b1;
      end else if (load_use_c) begin
        idex_d        = IDEX_BUBBLE;
        stall_fe      = 1'b1;
        loaduse_inc_c = 1'b1;
      end else if (id_valid) begin
        idex_d.valid   = 1'b1;
        idex_d.rs1     = id_rs1;
        idex_d.rs2     = id_rs2;
        idex_d.rd      = id_rd;
        idex_d.regwren = id_regwren;
        idex_d.memread = id_memread;
      end else begin
        idex_d = IDEX_BUBBLE;
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= IDEX_BUBBLE;
      exmem_q <= EXMEM_BUBBLE;
      memwb_q <= MEMWB_BUBBLE;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Forwarding-unit view; RegWrEn is gated by valid so bubbles never match
  always_comb begin
    IDEX_Rs1      = idex_q.rs1;
    IDEX_Rs2      = idex_q.rs2;
    EXMEM_Rd      = exmem_q.rd;
    MEMWB_Rd      = memwb_q.rd;
    EXMEM_RegWrEn = exmem_q.valid & exmem_q.regwren;
    MEMWB_RegWrEn = memwb_q.valid & memwb_q.regwren;
  end

  sat_counter #(.CNT_W(CNT_W)) u_loaduse_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (loaduse_inc_c),
    .count (loaduse_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc_c),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Directed bench for hazard_pipe_ctrl with a MEM/WB writeback scoreboard.
module tb_hazard_pipe_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid = 1'b0;
  logic [REG_AW-1:0] id_rs1 = '0;
  logic [REG_AW-1:0] id_rs2 = '0;
  logic              id_use_rs1 = 1'b0;
  logic              id_use_rs2 = 1'b0;
  logic [REG_AW-1:0] id_rd = '0;
  logic              id_regwren = 1'b0;
  logic              id_memread = 1'b0;
  logic              ex_flush = 1'b0;
  logic              mem_stall = 1'b0;
  logic [REG_AW-1:0] IDEX_Rs1, IDEX_Rs2, EXMEM_Rd, MEMWB_Rd;
  logic              EXMEM_RegWrEn, MEMWB_RegWrEn, stall_fe, flush_ifid;
  logic [CNT_W-1:0]  loaduse_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  logic [REG_AW-1:0] sb_q[$];
  logic              adv = 1'b0;

  always #5 clk = ~clk;

  hazard_pipe_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwren(id_regwren), .id_memread(id_memread),
    .ex_flush(ex_flush), .mem_stall(mem_stall),
    .IDEX_Rs1(IDEX_Rs1), .IDEX_Rs2(IDEX_Rs2),
    .EXMEM_Rd(EXMEM_Rd), .MEMWB_Rd(MEMWB_Rd),
    .EXMEM_RegWrEn(EXMEM_RegWrEn), .MEMWB_RegWrEn(MEMWB_RegWrEn),
    .stall_fe(stall_fe), .flush_ifid(flush_ifid),
    .loaduse_cnt(loaduse_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [REG_AW-1:0] rs1, input logic u1,
                       input logic [REG_AW-1:0] rs2, input logic u2,
                       input logic [REG_AW-1:0] rd, input logic wr, input logic mr);
    id_valid = v;  id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd;    id_regwren = wr; id_memread = mr;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // MEM/WB only takes a new record on an edge with no reset and no freeze
  always @(posedge clk) adv <= !rst && !mem_stall;

  // Each newly written-back instruction must be the oldest one issued
  always @(negedge clk) begin
    if (adv && MEMWB_RegWrEn === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_wb", 32'(MEMWB_Rd), 32'hFFFF_FFFF);
      end else begin
        chk("sb_memwb_rd", 32'(MEMWB_Rd), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset with flush/stall requests present: controls must stay low
    mem_stall = 1'b1;
    ex_flush  = 1'b1;
    tick();
    chk("rst_stall_fe", 32'(stall_fe), 0);
    chk("rst_flush_ifid", 32'(flush_ifid), 0);
    tick();
    rst = 1'b0; mem_stall = 1'b0; ex_flush = 1'b0;
    #1;
    chk("rst_idex_rs1", 32'(IDEX_Rs1), 0);
    chk("rst_idex_rs2", 32'(IDEX_Rs2), 0);
    chk("rst_exmem_rd", 32'(EXMEM_Rd), 0);
    chk("rst_memwb_rd", 32'(MEMWB_Rd), 0);
    chk("rst_exmem_wr", 32'(EXMEM_RegWrEn), 0);
    chk("rst_memwb_wr", 32'(MEMWB_RegWrEn), 0);
    chk("rst_stall_fe2", 32'(stall_fe), 0);
    chk("rst_flush_ifid2", 32'(flush_ifid), 0);
    chk("rst_loaduse_cnt", 32'(loaduse_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);

    // Load-use: lw x5 then add reading x5
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    #1 chk("lw5_no_stall", 32'(stall_fe), 0);
    sb_q.push_back(5'd5);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    chk("lu_stall_fe", 32'(stall_fe), 1);
    chk("lu_flush_ifid", 32'(flush_ifid), 0);
    chk("lu_idex_rs1_lw", 32'(IDEX_Rs1), 1);
    tick();
    chk("lu_bubble_rs1", 32'(IDEX_Rs1), 0);
    chk("lu_bubble_rs2", 32'(IDEX_Rs2), 0);
    chk("lu_exmem_rd", 32'(EXMEM_Rd), 5);
    chk("lu_exmem_wr", 32'(EXMEM_RegWrEn), 1);
    chk("lu_cnt", 32'(loaduse_cnt), 1);
    chk("lu_released", 32'(stall_fe), 0);
    sb_q.push_back(5'd6);
    tick();
    chk("lu_add_rs1", 32'(IDEX_Rs1), 5);
    chk("lu_add_rs2", 32'(IDEX_Rs2), 2);
    chk("lu_exmem_bubble_wr", 32'(EXMEM_RegWrEn), 0);
    chk("lu_memwb_rd", 32'(MEMWB_Rd), 5);
    chk("lu_memwb_wr", 32'(MEMWB_RegWrEn), 1);

    // Load to x0 followed by a reader of x0: never stalls
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    sb_q.push_back(5'd0);
    tick();
    drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
    #1 chk("x0_no_stall", 32'(stall_fe), 0);
    sb_q.push_back(5'd3);
    tick();
    chk("x0_idex_rs1", 32'(IDEX_Rs1), 4);
    chk("x0_loaduse_cnt", 32'(loaduse_cnt), 1);

    // Flush and load-use in the same cycle: flush wins
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
    sb_q.push_back(5'd10);
    tick();
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
    ex_flush = 1'b1;
    #1;
    chk("fl_flush_ifid", 32'(flush_ifid), 1);
    chk("fl_stall_fe", 32'(stall_fe), 0);
    tick();
    ex_flush = 1'b0;
    idle();
    chk("fl_bubble_rs1", 32'(IDEX_Rs1), 0);
    chk("fl_exmem_rd", 32'(EXMEM_Rd), 10);
    chk("fl_flush_cnt", 32'(flush_cnt), 1);
    chk("fl_loaduse_cnt", 32'(loaduse_cnt), 1);

    // Fill pipe with rd=7/8/9, then freeze for three cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, REG_AW'(17 + i), 1'b1, 5'd0, 1'b0, REG_AW'(7 + i), 1'b1, 1'b0);
      sb_q.push_back(REG_AW'(7 + i));
      tick();
    end
    drive(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    mem_stall = 1'b1;
    ex_flush  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ms_stall_fe", 32'(stall_fe), 1);
      chk("ms_flush_ifid", 32'(flush_ifid), 0);
      chk("ms_idex_rs1", 32'(IDEX_Rs1), 19);
      chk("ms_exmem_rd", 32'(EXMEM_Rd), 8);
      chk("ms_memwb_rd", 32'(MEMWB_Rd), 7);
      chk("ms_flush_cnt", 32'(flush_cnt), 1);
      tick();
    end
    // Release: the held flush is now taken
    mem_stall = 1'b0;
    #1;
    chk("ms_rel_flush_ifid", 32'(flush_ifid), 1);
    chk("ms_rel_stall_fe", 32'(stall_fe), 0);
    tick();
    chk("ms_adv_idex_rs1", 32'(IDEX_Rs1), 0);
    chk("ms_adv_exmem_rd", 32'(EXMEM_Rd), 9);
    chk("ms_adv_memwb_rd", 32'(MEMWB_Rd), 8);
    chk("ms_adv_flush_cnt", 32'(flush_cnt), 2);

    // Counter saturation with a 2-bit counter
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_flush_cnt", 32'(flush_cnt), 3);
    end
    ex_flush = 1'b0;

    // Reset in the middle of a freeze clears everything on that edge
    drive(1'b1, 5'd21, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    tick();
    idle();
    chk("pre_rst_idex_rs1", 32'(IDEX_Rs1), 21);
    mem_stall = 1'b1;
    rst = 1'b1;
    #1 chk("mid_rst_stall_fe", 32'(stall_fe), 0);
    tick();
    void'(sb_q.pop_back());
    rst = 1'b0;
    mem_stall = 1'b0;
    #1;
    chk("post_rst_idex_rs1", 32'(IDEX_Rs1), 0);
    chk("post_rst_exmem_wr", 32'(EXMEM_RegWrEn), 0);
    chk("post_rst_memwb_wr", 32'(MEMWB_RegWrEn), 0);
    chk("post_rst_stall_fe", 32'(stall_fe), 0);
    chk("post_rst_flush_cnt", 32'(flush_cnt), 0);
    chk("post_rst_loaduse_cnt", 32'(loaduse_cnt), 0);

    for (int i = 0; i < 4; i++) tick();
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
